// File: rtl/lc3b_types.sv
// Shared types for the LC-3b memory sequencer: memory operation codes,
// sequencer states and the default wait limit.
package lc3b_types;

    typedef enum logic [2:0] {
        READ_W    = 3'd0,
        READ_B    = 3'd1,
        WRITE_W   = 3'd2,
        WRITE_B   = 3'd3,
        READ_IND  = 3'd4,
        WRITE_IND = 3'd5
    } lc3b_memop;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PTR_RD = 3'd1,
        S_PTR_LD = 3'd2,
        S_ACC    = 3'd3,
        S_DONE   = 3'd4
    } seq_state_e;

    localparam int DEFAULT_TIMEOUT = 255;
    localparam int WAIT_CNT_W      = 16;

    // Codes 6 and 7 are unassigned and rejected without touching memory.
    function automatic logic op_is_legal(input logic [2:0] o);
        return o <= 3'd5;
    endfunction

    function automatic logic op_is_write(input logic [2:0] o);
        return (o == WRITE_W) || (o == WRITE_B) || (o == WRITE_IND);
    endfunction

    function automatic logic op_is_indirect(input logic [2:0] o);
        return (o == READ_IND) || (o == WRITE_IND);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting for mem_resp; expired flags the last allowed
// waiting cycle so the sequencer can leave on that same edge.
module mem_wait_timer
    import lc3b_types::*;
#(
    parameter int CNT_W = WAIT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             count,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (count) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // A zero limit means wait forever.
    assign expired = (limit != '0) && count && (cnt_q == limit - CNT_W'(1));

endmodule

// File: rtl/mem_sequencer.sv
// LC-3b style memory access sequencer: direct word/byte accesses and
// pointer-indirect word accesses with a bounded wait for mem_resp.
module mem_sequencer
    import lc3b_types::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic [2:0]          op,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [DATA_W-1:0]   rdata,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_read,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byte_enable,
    input  logic                mem_resp
);

    localparam int LANES  = DATA_W / 8;
    localparam int LANE_W = $clog2(LANES);

    seq_state_e        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              timer_clear, timer_count, timer_expired;
    logic [LANE_W-1:0] lane;
    logic [ADDR_W-1:0] aligned_addr;
    logic [DATA_W-1:0] wdata_rep;
    logic [LANES-1:0]  lane_onehot;
    logic [7:0]        rd_lane [LANES];
    logic [7:0]        rd_byte;

    assign lane         = addr_q[LANE_W-1:0];
    assign aligned_addr = {addr_q[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
    assign rd_byte      = rd_lane[lane];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign wdata_rep[gi*8 +: 8] = wdata_q[7:0];
        assign lane_onehot[gi]      = (lane == LANE_W'(gi));
        assign rd_lane[gi]          = mem_rdata[gi*8 +: 8];
    end

    mem_wait_timer #(.CNT_W(WAIT_CNT_W)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .count   (timer_count),
        .limit   (WAIT_CNT_W'(TIMEOUT)),
        .expired (timer_expired)
    );

    // Every state change restarts the wait count, which covers entry to PTR_RD and ACC.
    assign timer_clear = (state_d != state_q);
    assign timer_count = ((state_q == S_PTR_RD) || (state_q == S_ACC)) && !mem_resp;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    op_d    = op;
                    addr_d  = addr;
                    wdata_d = wdata;
                    err_d   = 1'b0;
                    if (!op_is_legal(op)) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else if (op_is_indirect(op)) begin
                        state_d = S_PTR_RD;
                    end else begin
                        state_d = S_ACC;
                    end
                end
            end
            S_PTR_RD: begin
                if (mem_resp) begin
                    addr_d  = ADDR_W'(mem_rdata);
                    state_d = S_PTR_LD;
                end else if (timer_expired) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_PTR_LD: state_d = S_ACC;
            S_ACC: begin
                if (mem_resp) begin
                    if (!op_is_write(op_q)) begin
                        rdata_d = (op_q == READ_B) ? DATA_W'(rd_byte) : mem_rdata;
                    end
                    state_d = S_DONE;
                end else if (timer_expired) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode only from registers, so an async reset drops strobes at once.
    always_comb begin
        busy            = (state_q != S_IDLE);
        done            = (state_q == S_DONE);
        err             = (state_q == S_DONE) && err_q;
        rdata           = rdata_q;
        mem_read        = (state_q == S_PTR_RD) || ((state_q == S_ACC) && !op_is_write(op_q));
        mem_write       = (state_q == S_ACC) && op_is_write(op_q);
        mem_address     = '0;
        mem_wdata       = '0;
        mem_byte_enable = '1;
        if ((state_q == S_PTR_RD) || (state_q == S_ACC)) begin
            mem_address = aligned_addr;
        end
        if (mem_write) begin
            mem_wdata = (op_q == WRITE_B) ? wdata_rep : wdata_q;
            if (op_q == WRITE_B) begin
                mem_byte_enable = lane_onehot;
            end
        end
    end

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer: direct, byte, indirect, timeout,
// illegal-op and mid-access reset scenarios with hand-computed values.
module tb_mem_sequencer;
    import lc3b_types::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [2:0]  op;
    logic [15:0] addr, wdata;
    logic        busy, done, err;
    logic [15:0] rdata, mem_address, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, mem_resp;
    logic [1:0]  mem_byte_enable;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_sequencer #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req             (req),
        .op              (op),
        .addr            (addr),
        .wdata           (wdata),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .rdata           (rdata),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_resp        (mem_resp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("[TB] check %-22s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request before the acceptance edge (cycle 0); returns in cycle 1.
    task automatic start(input logic [2:0] o, input logic [15:0] a, input logic [15:0] d);
        req   = 1'b1;
        op    = o;
        addr  = a;
        wdata = d;
        step();
        req   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; op = '0; addr = '0; wdata = '0;
        mem_rdata = '0; mem_resp = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done_err", {done, err}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_strobes", {mem_read, mem_write}, 0);
        check("rst_byte_en", mem_byte_enable, 2'b11);
        check("rst_addr_wdata", {mem_address, mem_wdata}, 0);
        step(); step();
        rst_n = 1'b1;
        step();

        // READ_W with a response on the first strobe cycle; inputs change while busy.
        start(READ_W, 16'h3001, 16'h0000);
        check("rw_c1_strobes", {busy, mem_read, mem_write, done}, 4'b1100);
        check("rw_c1_addr", mem_address, 16'h3000);
        check("rw_c1_be", mem_byte_enable, 2'b11);
        op = WRITE_W; addr = 16'hFFFF;
        mem_resp = 1'b1; mem_rdata = 16'h1234;
        step();
        check("rw_c2_done_err", {done, err, busy, mem_read}, 4'b1010);
        check("rw_c2_rdata", rdata, 16'h1234);
        mem_resp = 1'b0;
        req = 1'b1; op = READ_W; addr = 16'h0100;
        step();
        req = 1'b0;
        check("done_req_ignored", {busy, done, mem_read}, 0);
        step();
        check("rw_idle_after", busy, 0);

        // READ_B on both lanes.
        start(READ_B, 16'h3001, 16'h0000);
        check("rb_hi_strobe", {mem_read, mem_byte_enable}, 3'b111);
        mem_resp = 1'b1; mem_rdata = 16'hAB12;
        step();
        check("rb_hi_rdata", {done, rdata}, {1'b1, 16'h00AB});
        mem_resp = 1'b0;
        step();
        start(READ_B, 16'h3000, 16'h0000);
        mem_resp = 1'b1; mem_rdata = 16'hAB12;
        step();
        check("rb_lo_rdata", {done, rdata}, {1'b1, 16'h0012});
        mem_resp = 1'b0;
        step();

        // WRITE_B with two waiting cycles; rdata must stay untouched.
        start(WRITE_B, 16'h4001, 16'h0077);
        check("wb_c1_strobes", {mem_read, mem_write}, 2'b01);
        check("wb_c1_be", mem_byte_enable, 2'b10);
        check("wb_c1_wdata", mem_wdata, 16'h7777);
        step();
        check("wb_c2_held", {mem_write, mem_byte_enable, mem_wdata}, {1'b1, 2'b10, 16'h7777});
        step();
        check("wb_c3_held", {mem_write, done}, 2'b10);
        mem_resp = 1'b1;
        step();
        check("wb_done", {done, err, mem_write}, 3'b100);
        check("wb_rdata_kept", rdata, 16'h0012);
        mem_resp = 1'b0;
        step();

        // WRITE_W on an odd address writes the aligned word.
        start(WRITE_W, 16'h4003, 16'hBEEF);
        check("ww_addr_data", {mem_address, mem_wdata}, {16'h4002, 16'hBEEF});
        check("ww_be_strobe", {mem_write, mem_read, mem_byte_enable}, 4'b1011);
        mem_resp = 1'b1;
        step();
        check("ww_done", {done, err, rdata}, {2'b10, 16'h0012});
        mem_resp = 1'b0;
        step();

        // READ_IND: pointer read, pointer load (resp ignored), access, done at cycle 4.
        start(READ_IND, 16'h2000, 16'h0000);
        check("ri_c1_ptr_rd", {mem_read, mem_write, mem_address}, {2'b10, 16'h2000});
        mem_resp = 1'b1; mem_rdata = 16'h5000;
        step();
        check("ri_c2_ptr_ld", {busy, mem_read, mem_write, done}, 4'b1000);
        mem_rdata = 16'hDEAD;
        step();
        check("ri_c3_acc", {mem_read, mem_address}, {1'b1, 16'h5000});
        mem_rdata = 16'hBEEF;
        step();
        check("ri_c4_done", {done, err, rdata}, {2'b10, 16'hBEEF});
        mem_resp = 1'b0;
        step();

        // Timeout: four waiting cycles with strobe, then done with err.
        start(READ_W, 16'h1000, 16'h0000);
        step(); step(); step();
        check("to_c4_still_wait", {mem_read, done}, 2'b10);
        step();
        check("to_c5_err", {done, err, mem_read, mem_write}, 4'b1100);
        check("to_rdata_kept", rdata, 16'hBEEF);
        step();

        // Response on the last allowed waiting cycle still succeeds.
        start(READ_W, 16'h1000, 16'h0000);
        step(); step(); step();
        mem_resp = 1'b1; mem_rdata = 16'h0F0F;
        step();
        check("to_edge_ok", {done, err, rdata}, {2'b10, 16'h0F0F});
        mem_resp = 1'b0;
        step();

        // Illegal op: done+err at cycle 1, no strobe.
        start(3'd7, 16'h0000, 16'h0000);
        check("illegal_done_err", {done, err, mem_read, mem_write}, 4'b1100);
        step();
        check("illegal_idle", {busy, done}, 2'b00);

        // Reset during WRITE_W wait: strobe drops before any clock edge.
        start(WRITE_W, 16'h6000, 16'h1111);
        check("rstmid_write_on", mem_write, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_immediate", {mem_write, busy, done}, 3'b000);
        step();
        rst_n = 1'b1;
        step();
        check("rstmid_idle", {busy, done, mem_write}, 3'b000);
        step();
        check("rstmid_no_done", {done, err}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
